// File: rtl/routing_pkg.sv
// Shared definitions for the mesh routing unit.
//   CH_*    : output channel indices (0 local, 1 north, 2 east, 3 south, 4 west)
//   algo_e  : dimension order (XY = X first, YX = Y first)
//   state_e : route-hold FSM states
package routing_pkg;

   localparam int CH_LOCAL = 0;
   localparam int CH_NORTH = 1;
   localparam int CH_EAST  = 2;
   localparam int CH_SOUTH = 3;
   localparam int CH_WEST  = 4;

   typedef enum logic {
      ALGO_XY = 1'b0,
      ALGO_YX = 1'b1
   } algo_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/route_compute.sv
// Combinational next-hop computation for one input port.
// Optional macro: ROUTE_ADAPTIVE_EN -- when both dimensions are productive, prefer the
//   productive channel whose downstream is ready; tie (both/neither) falls back to ALGORITHM.
// Ports:
//   target_x / target_y : destination coordinates of the packet header
//   out_ready           : per-channel downstream ready (adaptive build only)
//   route               : one-hot output channel
//   out_of_mesh         : destination lies outside the mesh (route forced to local)
module route_compute
   import routing_pkg::*;
#(
   parameter int MAX_ROUTERS_X       = 4,
   parameter int MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X),
   parameter int MAX_ROUTERS_Y       = 4,
   parameter int MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y),
   parameter int ROUTER_X            = 0,
   parameter int ROUTER_Y            = 0,
   parameter int CHANNEL_NUMBER      = 5,
   parameter int ALGORITHM           = 0
) (
   input  logic [MAX_ROUTERS_X_WIDTH-1:0] target_x,
   input  logic [MAX_ROUTERS_Y_WIDTH-1:0] target_y,
`ifdef ROUTE_ADAPTIVE_EN
   input  logic [CHANNEL_NUMBER-1:0]      out_ready,
`endif
   output logic [CHANNEL_NUMBER-1:0]      route,
   output logic                           out_of_mesh
);

   localparam algo_e ALGO = (ALGORITHM == 1) ? ALGO_YX : ALGO_XY;
   localparam logic [CHANNEL_NUMBER-1:0] ONE = {{(CHANNEL_NUMBER-1){1'b0}}, 1'b1};

   logic [31:0] tx;
   logic [31:0] ty;
   logic        x_prod;
   logic        y_prod;
   logic        pick_y;
   int          x_ch;
   int          y_ch;
   int          ch;
`ifdef ROUTE_ADAPTIVE_EN
   logic        x_rdy;
   logic        y_rdy;
`endif

   assign tx = 32'(target_x);
   assign ty = 32'(target_y);

   always_comb begin
      x_prod      = (tx != 32'(ROUTER_X));
      y_prod      = (ty != 32'(ROUTER_Y));
      x_ch        = (tx > 32'(ROUTER_X)) ? CH_EAST : CH_WEST;
      y_ch        = (ty < 32'(ROUTER_Y)) ? CH_NORTH : CH_SOUTH;
      out_of_mesh = (tx >= 32'(MAX_ROUTERS_X)) || (ty >= 32'(MAX_ROUTERS_Y));
      pick_y      = (ALGO == ALGO_YX);
`ifdef ROUTE_ADAPTIVE_EN
      x_rdy = (tx > 32'(ROUTER_X)) ? out_ready[CH_EAST] : out_ready[CH_WEST];
      y_rdy = (ty < 32'(ROUTER_Y)) ? out_ready[CH_NORTH] : out_ready[CH_SOUTH];
      // exactly one productive channel ready: take it, otherwise keep dimension order
      if (x_rdy != y_rdy) begin
         pick_y = y_rdy;
      end
`endif
      // out-of-mesh goes local so the packet still drains
      if (out_of_mesh || (!x_prod && !y_prod)) begin
         ch = CH_LOCAL;
      end else if (!x_prod) begin
         ch = y_ch;
      end else if (!y_prod) begin
         ch = x_ch;
      end else begin
         ch = pick_y ? y_ch : x_ch;
      end
      route = ONE << ch;
   end

endmodule

// File: rtl/routing_unit_fsm.sv
// Per-input-port route computation and hold unit for the mesh cross-router.
// Latches a one-hot output selector on the packet header and holds it until the last
// beat transfers, steering valid/ready between the input and the selected output.
// Optional macro: ROUTE_ADAPTIVE_EN (ready-aware choice between productive dimensions).
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   target_x_i, target_y_i  : destination, sampled when a header arrives in IDLE
//   valid_i, last_i         : upstream beat valid / last beat of packet
//   ready_o                 : upstream ready (selected channel's downstream ready)
//   out_ready_i, valid_o    : per-channel downstream ready / valid
//   selector_o              : latched one-hot route, zero when idle
//   busy_o                  : packet in flight
//   err_o                   : sticky out-of-mesh destination flag
//   pkt_cnt_o               : completed packets, saturating
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no route held; a valid header is routed and latched
// ST_HOLD | route latched; beats forwarded until last beat transfers
module routing_unit_fsm
   import routing_pkg::*;
#(
   parameter int MAX_ROUTERS_X       = 4,
   parameter int MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X),
   parameter int MAX_ROUTERS_Y       = 4,
   parameter int MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y),
   parameter int ROUTER_X            = 0,
   parameter int ROUTER_Y            = 0,
   parameter int CHANNEL_NUMBER      = 5,
   parameter int ALGORITHM           = 0,
   parameter int CNT_WIDTH           = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [MAX_ROUTERS_X_WIDTH-1:0] target_x_i,
   input  logic [MAX_ROUTERS_Y_WIDTH-1:0] target_y_i,
   input  logic                           valid_i,
   input  logic                           last_i,
   output logic                           ready_o,
   input  logic [CHANNEL_NUMBER-1:0]      out_ready_i,
   output logic [CHANNEL_NUMBER-1:0]      valid_o,
   output logic [CHANNEL_NUMBER-1:0]      selector_o,
   output logic                           busy_o,
   output logic                           err_o,
   output logic [CNT_WIDTH-1:0]           pkt_cnt_o
);

   if (CHANNEL_NUMBER < 5) begin : g_bad_channels
      $error("routing_unit_fsm: CHANNEL_NUMBER must be at least 5");
   end

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_e                    state;
   state_e                    state_nxt;
   logic [CHANNEL_NUMBER-1:0] selector;
   logic [CHANNEL_NUMBER-1:0] selector_nxt;
   logic [CHANNEL_NUMBER-1:0] route;
   logic                      out_of_mesh;
   logic                      err;
   logic                      err_nxt;
   logic [CNT_WIDTH-1:0]      cnt;
   logic [CNT_WIDTH-1:0]      cnt_nxt;
   logic                      hold;
   logic                      rdy;

   route_compute #(
      .MAX_ROUTERS_X       (MAX_ROUTERS_X),
      .MAX_ROUTERS_X_WIDTH (MAX_ROUTERS_X_WIDTH),
      .MAX_ROUTERS_Y       (MAX_ROUTERS_Y),
      .MAX_ROUTERS_Y_WIDTH (MAX_ROUTERS_Y_WIDTH),
      .ROUTER_X            (ROUTER_X),
      .ROUTER_Y            (ROUTER_Y),
      .CHANNEL_NUMBER      (CHANNEL_NUMBER),
      .ALGORITHM           (ALGORITHM)
   ) u_route (
      .target_x    (target_x_i),
      .target_y    (target_y_i),
`ifdef ROUTE_ADAPTIVE_EN
      .out_ready   (out_ready_i),
`endif
      .route       (route),
      .out_of_mesh (out_of_mesh)
   );

   always_comb begin
      state_nxt    = state;
      selector_nxt = selector;
      err_nxt      = err;
      cnt_nxt      = cnt;
      hold         = (state == ST_HOLD);
      rdy          = hold & |(selector & out_ready_i);
      case (state)
         ST_IDLE: begin
            // header is only inspected here; upstream keeps it valid until HOLD accepts it
            if (valid_i) begin
               selector_nxt = route;
               err_nxt      = err | out_of_mesh;
               state_nxt    = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (valid_i && rdy && last_i) begin
               selector_nxt = '0;
               state_nxt    = ST_IDLE;
               if (cnt != '1) begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
         end
         default: begin
            state_nxt    = ST_IDLE;
            selector_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         selector <= '0;
         err      <= 1'b0;
         cnt      <= '0;
      end else begin
         state    <= state_nxt;
         selector <= selector_nxt;
         err      <= err_nxt;
         cnt      <= cnt_nxt;
      end
   end

   assign ready_o    = rdy;
   assign valid_o    = hold ? (selector & {CHANNEL_NUMBER{valid_i}}) : '0;
   assign selector_o = selector;
   assign busy_o     = hold;
   assign err_o      = err;
   assign pkt_cnt_o  = cnt;

endmodule
